// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-conversion arbiter: FSM state type,
// width-generic binary-to-Gray helper and the requester-ID width rule.
package gray_pkg;

  localparam int unsigned GRAY_MAXW = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  // Callers zero-extend their word to GRAY_MAXW and cast the result back
  // down. The zero above the word's MSB makes the MSB pass through unchanged.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A single requester still gets a one-bit ID so that the port never collapses.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts at ptr_i and wraps around.
// It returns a one-hot grant and the binary index of the winner.
// The index is valid whenever any request is present, even if enable_i is low.
module rr_arbiter
  import gray_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  input  logic           enable_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o
);

  logic           found;
  logic [IDW-1:0] cand;

  // Walk requesters from ptr_i upward and take the first asserted request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (enable_i && found) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one binary-to-Gray converter among N requesters.
// A round-robin winner's word is converted and registered into a
// valid/ready output slot, tagged with the winner's index.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter  int N   = 4,
  parameter  int W   = 3,
  localparam int IDW = calc_idw(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_bin,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  output logic [W-1:0]   out_gray,
  output logic [IDW-1:0] out_id,
  input  logic           out_ready
);

  state_e         state_q, state_d;
  logic [W-1:0]   gray_q, gray_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win_idx;
  logic [W-1:0]   win_word;
  logic           can_accept;
  logic           arb_en;
  logic           granted;

  // The output slot can take a new word when it is empty or is being drained.
  // Holding the arbiter off while rst_n is low keeps gnt quiet during reset.
  assign can_accept = (state_q == IDLE) || out_ready;
  assign arb_en     = can_accept && rst_n;
  assign granted    = |gnt;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .enable_i (arb_en),
    .gnt_o    (gnt),
    .idx_o    (win_idx)
  );

  // Select the winner's binary word from the packed request bus.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IDW'(i)) begin
        win_word = req_bin[i*W +: W];
      end
    end
  end

  // Next state: reload on grant, fall back to IDLE when the last result drains.
  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (granted) begin
      state_d = VALID;
      gray_d  = W'(bin2gray(GRAY_MAXW'(win_word)));
      id_d    = win_idx;
      ptr_d   = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
    end else if ((state_q == VALID) && out_ready) begin
      state_d = IDLE;
    end
  end

  // State, result slot and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gray_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == VALID);
  assign out_gray  = gray_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (N=4, W=3). It runs the directed
// scenarios and then random traffic against a transaction-level reference model.
module tb_gray_conv_arbiter;

  localparam int N   = 4;
  localparam int W   = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_bin;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_gray;
  logic [IDW-1:0] out_id;
  logic           out_ready;

  int errors = 0;
  int checks = 0;

  // Reference model: the content of the output slot and the rotation pointer.
  bit           m_valid;
  int           m_ptr;
  logic [W-1:0] m_gray;
  int           m_id;
  logic [W-1:0] gray_tab [1<<W];

  gray_conv_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_bin   (req_bin),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Build the Gray sequence by reflection. Code n is the Gray code of binary n.
  task automatic build_gray_tab();
    int len;
    len = 1;
    gray_tab[0] = '0;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < len; i++) begin
        gray_tab[2*len-1-i] = gray_tab[i] | W'(1 << b);
      end
      len = len * 2;
    end
  endtask

  // Expected grant: the first requester at or after the pointer, if the slot can accept.
  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (rst_n && (!m_valid || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          g[c] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  // Advance one clock. The model applies the grant it predicted for the current inputs.
  task automatic tick();
    logic [N-1:0] g;
    g = exp_gnt();
    @(posedge clk);
    if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_valid = 1'b1;
          m_gray  = gray_tab[req_bin[i*W +: W]];
          m_id    = i;
          m_ptr   = (i + 1) % N;
        end
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_gray  = '0;
    m_id    = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_bin   = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = '1;
    req_bin   = '1;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_gray !== '0) begin errors++; $display("FAIL reset_gray: got %b expected 000", out_gray); end
    checks++; if (out_id !== '0) begin errors++; $display("FAIL reset_id: got %0d expected 0", out_id); end
    req   = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    req     = 4'b0001;
    req_bin = '0;
    req_bin[2:0] = 3'b101;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    tick();
    req = '0;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_gray !== 3'b111) begin errors++; $display("FAIL single_gray: got %b expected 111", out_gray); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", out_id); end
    tick();
  endtask

  task automatic test_exhaustive();
    logic [W-1:0] exp_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    do_reset();
    req       = 4'b0100;
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      req_bin[2*W +: W] = W'(v);
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL exh_gnt[%0d]: got %b expected 0100", v, gnt); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL exh_valid[%0d]: got %b expected 1", v, out_valid); end
      checks++; if (out_gray !== exp_tab[v]) begin errors++; $display("FAIL exh_gray[%0d]: got %b expected %b", v, out_gray, exp_tab[v]); end
      checks++; if (out_id !== 2'd2) begin errors++; $display("FAIL exh_id[%0d]: got %0d expected 2", v, out_id); end
    end
    req = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exh_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    do_reset();
    req       = 4'b1111;
    req_bin   = N*W'($urandom);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      eg = '0;
      eg[k] = 1'b1;
      #1;
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, eg); end
      tick();
      req[k]  = 1'b0;
      req_bin = N*W'($urandom);
      checks++; if (out_id !== IDW'(k)) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, out_id, k); end
      checks++; if (out_gray !== m_gray) begin errors++; $display("FAIL rr_gray[%0d]: got %b expected %b", k, out_gray, m_gray); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", out_valid); end
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap: got %b expected 0001", gnt); end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req     = 4'b0001;
    req_bin = '0;
    req_bin[2:0] = 3'b011;
    tick();
    req       = 4'b0010;
    req_bin   = N*W'($urandom);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (gnt !== '0) begin errors++; $display("FAIL bp_gnt[%0d]: got %b expected 0000", c, gnt); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
      checks++; if (out_gray !== 3'b010) begin errors++; $display("FAIL bp_gray[%0d]: got %b expected 010", c, out_gray); end
      checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL bp_id[%0d]: got %0d expected 0", c, out_id); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_release_gnt: got %b expected 0010", gnt); end
    tick();
    req = '0;
    checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL bp_new_id: got %0d expected 1", out_id); end
    checks++; if (out_gray !== m_gray) begin errors++; $display("FAIL bp_new_gray: got %b expected %b", out_gray, m_gray); end
    tick();
  endtask

  task automatic test_idle_return();
    do_reset();
    req       = 4'b0001;
    req_bin   = N*W'($urandom);
    out_ready = 1'b1;
    tick();
    req = '0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL idle_valid: got %b expected 1", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_fall: got %b expected 0", out_valid); end
    repeat (2) begin
      #1;
      checks++; if (gnt !== '0) begin errors++; $display("FAIL idle_gnt: got %b expected 0000", gnt); end
      tick();
    end
    req = 4'b0011;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL idle_ptr: got %b expected 0010", gnt); end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req       = 4'b0100;
    req_bin   = N*W'($urandom);
    out_ready = 1'b0;
    tick();
    req = 4'b1000;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    checks++; if (out_gray !== '0) begin errors++; $display("FAIL arst_gray: got %b expected 000", out_gray); end
    checks++; if (out_id !== '0) begin errors++; $display("FAIL arst_id: got %0d expected 0", out_id); end
    checks++; if (gnt !== '0) begin errors++; $display("FAIL arst_gnt: got %b expected 0000", gnt); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL arst_regrant: got %b expected 1000", gnt); end
    tick();
    checks++; if (out_id !== 2'd3) begin errors++; $display("FAIL arst_id3: got %0d expected 3", out_id); end
    req = 4'b0011;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL arst_ptr: got %b expected 0001", gnt); end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    int waits [N];
    do_reset();
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      req_bin   = N*W'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
      #1;
      g = exp_gnt();
      checks++; if (gnt !== g) begin errors++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", cyc, gnt, g); end
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (out_gray !== m_gray) begin errors++; $display("FAIL rnd_gray[%0d]: got %b expected %b", cyc, out_gray, m_gray); end
        checks++; if (out_id !== IDW'(m_id)) begin errors++; $display("FAIL rnd_id[%0d]: got %0d expected %0d", cyc, out_id, m_id); end
      end
      if (g != '0) begin
        for (int i = 0; i < N; i++) begin
          if (g[i]) begin
            checks++; if (waits[i] > N - 1) begin errors++; $display("FAIL rnd_fair[%0d]: requester %0d waited %0d grants, limit %0d", cyc, i, waits[i], N - 1); end
            waits[i] = 0;
          end else if (req[i]) begin
            waits[i]++;
          end
        end
      end
      tick();
      req = req & ~g;
    end
    req = '0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    build_gray_tab();
    test_reset();
    test_single();
    test_exhaustive();
    test_round_robin();
    test_backpressure();
    test_idle_return();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
